data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
- REQ-001 SHALL have parameter NB_DATA, default 32: data word width in bits.
- REQ-002 SHALL have parameter N_WORDS, default 64: memory depth in words.
- REQ-003 SHALL have parameter NB_ADDR_MEM, default log2(N_WORDS): word-index width.
- REQ-004 SHALL have i_clk, input, 1: single clock; all state changes on the rising edge.
- REQ-005 SHALL have i_reset, input, 1: reset, synchronous and active-high.
- REQ-006 SHALL have i_mem_addr, input, NB_DATA: byte address from the memory_access stage.
- REQ-007 SHALL have i_mem_wdata, input, NB_DATA: store data, right-aligned.
- REQ-008 SHALL have i_mem_read and i_mem_write, each input, 1: load strobe and store strobe.
- REQ-009 SHALL have i_mem_size, input, 2: access size, 00 byte, 01 halfword, 10 word; 11 is treated as word.
- REQ-010 SHALL have i_mem_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
- REQ-011 SHALL have o_mem_rdata, output, NB_DATA: registered, extended load result.
- REQ-012 SHALL have i_dump_start, input, 1: debug request for a full memory dump.
- REQ-013 SHALL have i_dump_ready, input, 1: debug consumer accepts the current dump word.
- REQ-014 SHALL have o_dump_valid, output, 1: o_dump_data and o_dump_addr are valid.
- REQ-015 SHALL have o_dump_data, output, NB_DATA: dumped word.
- REQ-016 SHALL have o_dump_addr, output, NB_ADDR_MEM: word index of o_dump_data.
- REQ-017 SHALL have o_dump_done, output, 1: one-cycle pulse after the last word is accepted.
- REQ-018 SHALL have o_misaligned, output, 1: misaligned-access flag; present only with the macro in REQ-036.

Function
- REQ-019 SHALL index the word array by i_mem_addr[NB_ADDR_MEM+1:2]; higher address bits are ignored, so addresses wrap modulo N_WORDS words.
- REQ-020 SHALL write on the clock edge when i_mem_write=1:
  - byte: lane addr[1:0] gets wdata[7:0];
  - halfword: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0];
  - word: all lanes;
  - other lanes unchanged; lane 0 is bits 7:0 (little-endian).
- REQ-021 SHALL register o_mem_rdata one cycle after i_mem_read=1, with the lane selection matching REQ-020 and extension per i_mem_unsigned.
- REQ-022 SHALL hold o_mem_rdata unchanged in cycles where i_mem_read=0.
- REQ-023 SHALL return old data (read-before-write) when i_mem_read and i_mem_write are both 1 to the same word.
- REQ-024 SHALL implement the dump FSM:
  - IDLE -> SEND on i_dump_start; index 0 is loaded and o_dump_valid asserts the next cycle.
  - SEND: hold data and address while i_dump_ready=0; advance the index on valid&ready.
  - SEND -> DONE on acceptance of index N_WORDS-1.
  - DONE: pulse o_dump_done for one cycle, then return to IDLE.
- REQ-025 SHALL ignore i_dump_start while in SEND or DONE.
- REQ-026 SHALL read dump data through a second read port, so pipeline accesses proceed concurrently with a dump.
- REQ-027 SHALL, for a pipeline write to the word currently presented, show the new value on o_dump_data the cycle after the write, while that word is still unaccepted.
- REQ-028 SHALL allow a sustained dump with i_dump_ready=1 throughout to take exactly N_WORDS cycles of o_dump_valid.

Reset
- REQ-029 SHALL, on i_reset=1 at a clock edge, clear o_mem_rdata, o_dump_valid, o_dump_data, o_dump_addr, o_dump_done and o_misaligned to 0, and put the FSM in IDLE.
- REQ-030 SHALL clear all memory words to 0 on reset.
- REQ-031 SHALL abort a dump in progress on reset mid-dump without pulsing o_dump_done.
- REQ-032 SHALL have reset take priority over all strobes in the same cycle.

Configuration
- REQ-033 SHALL treat a halfword access with addr[0]=1 as misaligned.
- REQ-034 SHALL treat a word access with addr[1:0]≠00 as misaligned.
- REQ-035 SHALL perform no alignment check when DATA_MEMORY_MISALIGN_TRAP_EN is undefined: misaligned low address bits are ignored (forced to the aligned lane) and o_misaligned is absent.
- REQ-036 SHALL, when DATA_MEMORY_MISALIGN_TRAP_EN is defined:
  - suppress a misaligned write;
  - leave o_mem_rdata unchanged on a misaligned read;
  - register o_misaligned=1 for the cycle after the access; 0 otherwise.

Verification
- REQ-037 SHALL cover: word store 0x8000_00F1 at addr 0x10, then word load at 0x10 -> o_mem_rdata=0x8000_00F1 one cycle after the load strobe.
- REQ-038 SHALL cover: byte store 0xAB at addr 0x13, signed byte load at 0x13 -> 0xFFFF_FFAB; unsigned byte load -> 0x0000_00AB; word load at 0x10 -> 0xAB00_00F1.
- REQ-039 SHALL cover: word store at addr 0x100 (N_WORDS=64) -> word 0 modified (wrap-around).
- REQ-040 SHALL cover: dump with i_dump_ready=1 -> 64 valid beats, addresses 0..63, then an o_dump_done pulse; dump with ready toggling every other cycle -> data held while ready=0, no index skipped.
- REQ-041 SHALL cover: reset asserted at dump index 20 -> o_dump_valid=0 next cycle, no o_dump_done, all words read 0.
- REQ-042 SHALL cover: with DATA_MEMORY_MISALIGN_TRAP_EN, word store 0xFFFF_FFFF at addr 0x22 -> o_misaligned=1 for one cycle, word 8 unchanged; without the macro -> word 8 = 0xFFFF_FFFF.

Source files
------------

// File: rtl/data_memory_if.sv
// Bus bundle for data_memory: pipeline load/store port plus debug dump stream.
// Signal names keep the i_/o_ prefixes as seen from the memory side.
// Optional misalignment flag is present only with DATA_MEMORY_MISALIGN_TRAP_EN.
interface data_memory_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR_MEM = 6
);
  logic [NB_DATA-1:0]     i_mem_addr;
  logic [NB_DATA-1:0]     i_mem_wdata;
  logic                   i_mem_read;
  logic                   i_mem_write;
  logic [1:0]             i_mem_size;
  logic                   i_mem_unsigned;
  logic [NB_DATA-1:0]     o_mem_rdata;
  logic                   i_dump_start;
  logic                   i_dump_ready;
  logic                   o_dump_valid;
  logic [NB_DATA-1:0]     o_dump_data;
  logic [NB_ADDR_MEM-1:0] o_dump_addr;
  logic                   o_dump_done;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
  logic                   o_misaligned;
`endif

  // Pipeline / debug side
  modport master (
    output i_mem_addr, i_mem_wdata, i_mem_read, i_mem_write, i_mem_size,
    output i_mem_unsigned, i_dump_start, i_dump_ready,
    input  o_mem_rdata, o_dump_valid, o_dump_data, o_dump_addr, o_dump_done
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    , input o_misaligned
`endif
  );

  // Memory side
  modport slave (
    input  i_mem_addr, i_mem_wdata, i_mem_read, i_mem_write, i_mem_size,
    input  i_mem_unsigned, i_dump_start, i_dump_ready,
    output o_mem_rdata, o_dump_valid, o_dump_data, o_dump_addr, o_dump_done
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    , output o_misaligned
`endif
  );
endinterface

// File: rtl/data_memory.sv
// data_memory: byte-addressed, little-endian data memory with byte/half/word
// loads and stores, registered load result, and a second read port that
// streams the whole array out through a valid/ready dump interface.
// Optional alignment trap: DATA_MEMORY_MISALIGN_TRAP_EN (default off).
module data_memory #(
  parameter int NB_DATA     = 32,
  parameter int N_WORDS     = 64,
  parameter int NB_ADDR_MEM = $clog2(N_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  data_memory_if.slave  mem_bus
);

  localparam logic [NB_ADDR_MEM-1:0] LAST_IDX = NB_ADDR_MEM'(N_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  logic [NB_DATA-1:0]     mem [N_WORDS];

  logic [NB_ADDR_MEM-1:0] word_idx;
  logic [1:0]             byte_lane;
  logic                   half_sel;
  logic                   is_byte;
  logic                   is_half;
  logic [NB_DATA-1:0]     cur_word;
  logic [NB_DATA-1:0]     merged_word;
  logic [NB_DATA-1:0]     load_value;
  logic                   wr_en;
  logic                   rd_en;
  logic                   unused_addr_hi;

  dump_state_t            state;
  dump_state_t            state_next;
  logic [NB_ADDR_MEM-1:0] dump_idx;
  logic [NB_ADDR_MEM-1:0] dump_idx_next;

  // Upper address bits do not take part in word selection (wrap-around).
  assign unused_addr_hi = &{1'b0, mem_bus.i_mem_addr[NB_DATA-1:NB_ADDR_MEM+2]};

  assign word_idx  = mem_bus.i_mem_addr[NB_ADDR_MEM+1:2];
  assign byte_lane = mem_bus.i_mem_addr[1:0];
  assign half_sel  = mem_bus.i_mem_addr[1];
  assign is_byte   = (mem_bus.i_mem_size == 2'b00);
  assign is_half   = (mem_bus.i_mem_size == 2'b01);
  assign cur_word  = mem[word_idx];

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
  logic misaligned;
  logic misaligned_q;

  // Halfword needs addr[0]=0; word (and size 11) needs addr[1:0]=00.
  assign misaligned = (is_half && mem_bus.i_mem_addr[0]) ||
                      (!is_byte && !is_half && (byte_lane != 2'b00));
  assign wr_en = mem_bus.i_mem_write && !misaligned;
  assign rd_en = mem_bus.i_mem_read  && !misaligned;

  // Flag a misaligned access for the cycle following it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned && (mem_bus.i_mem_read || mem_bus.i_mem_write);
    end
  end

  assign mem_bus.o_misaligned = misaligned_q;
`else
  assign wr_en = mem_bus.i_mem_write;
  assign rd_en = mem_bus.i_mem_read;
`endif

  // Store merge: replace only the addressed lanes of the current word.
  always_comb begin
    merged_word = cur_word;
    if (is_byte) begin
      merged_word[{byte_lane, 3'b000} +: 8] = mem_bus.i_mem_wdata[7:0];
    end else if (is_half) begin
      merged_word[{half_sel, 4'b0000} +: 16] = mem_bus.i_mem_wdata[15:0];
    end else begin
      merged_word = mem_bus.i_mem_wdata;
    end
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte   = cur_word[{byte_lane, 3'b000} +: 8];
    sel_half   = cur_word[{half_sel, 4'b0000} +: 16];
    load_value = cur_word;
    if (is_byte) begin
      load_value = {{(NB_DATA-8){sel_byte[7] & ~mem_bus.i_mem_unsigned}}, sel_byte};
    end else if (is_half) begin
      load_value = {{(NB_DATA-16){sel_half[15] & ~mem_bus.i_mem_unsigned}}, sel_half};
    end
  end

  // Storage array: cleared on reset, written on an enabled store.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[word_idx] <= merged_word;
    end
  end

  // Registered load result; reads the pre-write contents and holds otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_bus.o_mem_rdata <= '0;
    end else if (rd_en) begin
      mem_bus.o_mem_rdata <= load_value;
    end
  end

  // Dump FSM state and index registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      dump_idx <= '0;
    end else begin
      state    <= state_next;
      dump_idx <= dump_idx_next;
    end
  end

  // Dump FSM next-state: start only from IDLE, advance on valid&ready.
  always_comb begin
    state_next    = state;
    dump_idx_next = dump_idx;
    case (state)
      ST_IDLE: begin
        if (mem_bus.i_dump_start) begin
          state_next    = ST_SEND;
          dump_idx_next = '0;
        end
      end
      ST_SEND: begin
        if (mem_bus.i_dump_ready) begin
          if (dump_idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            dump_idx_next = dump_idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Second read port: the presented word is read live, so a pipeline store
  // to it shows up on the next cycle while it is still waiting for ready.
  assign mem_bus.o_dump_valid = (state == ST_SEND);
  assign mem_bus.o_dump_done  = (state == ST_DONE);
  assign mem_bus.o_dump_addr  = dump_idx;
  assign mem_bus.o_dump_data  = (state == ST_SEND) ? mem[dump_idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory (N_WORDS=64, NB_DATA=32).
// Build with or without DATA_MEMORY_MISALIGN_TRAP_EN.
module tb_data_memory;

  localparam int NB_DATA     = 32;
  localparam int N_WORDS     = 64;
  localparam int NB_ADDR_MEM = 6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_mem [N_WORDS];

  data_memory_if #(.NB_DATA(NB_DATA), .NB_ADDR_MEM(NB_ADDR_MEM)) bus ();

  data_memory #(
    .NB_DATA    (NB_DATA),
    .N_WORDS    (N_WORDS),
    .NB_ADDR_MEM(NB_ADDR_MEM)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .mem_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.i_mem_addr  = a;
    bus.i_mem_wdata = d;
    bus.i_mem_size  = sz;
    bus.i_mem_write = 1'b1;
    tick();
    bus.i_mem_write = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    bus.i_mem_addr     = a;
    bus.i_mem_size     = sz;
    bus.i_mem_unsigned = uns;
    bus.i_mem_read     = 1'b1;
    tick();
    bus.i_mem_read = 1'b0;
  endtask

  task automatic dump_full();
    bus.i_dump_ready = 1'b1;
    bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    for (int i = 0; i < N_WORDS; i++) begin
      chk("dump_valid", {31'd0, bus.o_dump_valid}, 32'd1);
      chk("dump_addr", {26'd0, bus.o_dump_addr}, i);
      chk("dump_data", bus.o_dump_data, exp_mem[i]);
      tick();
    end
    chk("dump_done_pulse", {31'd0, bus.o_dump_done}, 32'd1);
    chk("dump_valid_after", {31'd0, bus.o_dump_valid}, 32'd0);
    tick();
    chk("dump_done_clear", {31'd0, bus.o_dump_done}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < N_WORDS; i++) exp_mem[i] = 32'h0;

    // Reset with strobes active: reset wins.
    rst                = 1'b1;
    bus.i_mem_addr     = 32'h0;
    bus.i_mem_wdata    = 32'hFFFF_FFFF;
    bus.i_mem_read     = 1'b1;
    bus.i_mem_write    = 1'b1;
    bus.i_mem_size     = 2'b10;
    bus.i_mem_unsigned = 1'b0;
    bus.i_dump_start   = 1'b1;
    bus.i_dump_ready   = 1'b0;
    tick();
    tick();
    rst              = 1'b0;
    bus.i_mem_read   = 1'b0;
    bus.i_mem_write  = 1'b0;
    bus.i_dump_start = 1'b0;
    chk("rst_rdata", bus.o_mem_rdata, 32'h0);
    chk("rst_dump_valid", {31'd0, bus.o_dump_valid}, 32'd0);
    chk("rst_dump_done", {31'd0, bus.o_dump_done}, 32'd0);
    chk("rst_dump_addr", {26'd0, bus.o_dump_addr}, 32'd0);
    chk("rst_dump_data", bus.o_dump_data, 32'h0);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    chk("rst_misaligned", {31'd0, bus.o_misaligned}, 32'd0);
`endif
    load(32'h0, 2'b10, 1'b0);
    chk("rst_word0", bus.o_mem_rdata, 32'h0);

    // Word store / load.
    store(32'h10, 32'h8000_00F1, 2'b10);
    exp_mem[4] = 32'h8000_00F1;
    load(32'h10, 2'b10, 1'b0);
    chk("word_load", bus.o_mem_rdata, 32'h8000_00F1);
    bus.i_mem_addr = 32'h0;
    tick();
    chk("rdata_hold", bus.o_mem_rdata, 32'h8000_00F1);

    // Byte store and extended byte loads.
    store(32'h13, 32'h0000_00AB, 2'b00);
    exp_mem[4] = 32'hAB00_00F1;
    load(32'h13, 2'b00, 1'b0);
    chk("byte_signed", bus.o_mem_rdata, 32'hFFFF_FFAB);
    load(32'h13, 2'b00, 1'b1);
    chk("byte_unsigned", bus.o_mem_rdata, 32'h0000_00AB);
    load(32'h10, 2'b10, 1'b0);
    chk("word_after_byte", bus.o_mem_rdata, 32'hAB00_00F1);

    // Halfword store into upper half of word 5.
    store(32'h16, 32'h1234_8765, 2'b01);
    exp_mem[5] = 32'h8765_0000;
    load(32'h16, 2'b01, 1'b0);
    chk("half_signed", bus.o_mem_rdata, 32'hFFFF_8765);
    load(32'h16, 2'b01, 1'b1);
    chk("half_unsigned", bus.o_mem_rdata, 32'h0000_8765);
    load(32'h17, 2'b00, 1'b1);
    chk("byte3_unsigned", bus.o_mem_rdata, 32'h0000_0087);
    load(32'h14, 2'b11, 1'b0);
    chk("size11_word", bus.o_mem_rdata, 32'h8765_0000);

    // Wrap-around: 0x100 maps to word 0.
    store(32'h100, 32'hCAFE_BABE, 2'b10);
    exp_mem[0] = 32'hCAFE_BABE;
    load(32'h0, 2'b10, 1'b0);
    chk("wrap_word0", bus.o_mem_rdata, 32'hCAFE_BABE);

    // Read-before-write on the same word.
    bus.i_mem_read = 1'b1;
    store(32'h10, 32'h1111_1111, 2'b10);
    bus.i_mem_read = 1'b0;
    exp_mem[4] = 32'h1111_1111;
    chk("rbw_old", bus.o_mem_rdata, 32'hAB00_00F1);
    load(32'h10, 2'b10, 1'b0);
    chk("rbw_new", bus.o_mem_rdata, 32'h1111_1111);

    // Misaligned word store at 0x22.
    store(32'h22, 32'hFFFF_FFFF, 2'b10);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    chk("mis_flag_set", {31'd0, bus.o_misaligned}, 32'd1);
    tick();
    chk("mis_flag_clear", {31'd0, bus.o_misaligned}, 32'd0);
    load(32'h20, 2'b10, 1'b0);
    chk("mis_word8_kept", bus.o_mem_rdata, 32'h0);
    load(32'h10, 2'b10, 1'b0);
    load(32'h11, 2'b01, 1'b0);
    chk("mis_read_hold", bus.o_mem_rdata, 32'h1111_1111);
    chk("mis_read_flag", {31'd0, bus.o_misaligned}, 32'd1);
`else
    exp_mem[8] = 32'hFFFF_FFFF;
    load(32'h20, 2'b10, 1'b0);
    chk("nomis_word8", bus.o_mem_rdata, 32'hFFFF_FFFF);
`endif

    // Sustained dump.
    dump_full();

    // Dump with ready toggling, a late start request, and a store to the
    // presented word while it is stalled.
    begin
      int   exp_idx;
      logic injected;
      logic done_seen;
      exp_idx   = 0;
      injected  = 1'b0;
      done_seen = 1'b0;
      bus.i_dump_ready = 1'b0;
      bus.i_dump_start = 1'b1;
      tick();
      bus.i_dump_start = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        logic do_wr;
        do_wr = 1'b0;
        bus.i_dump_ready = cyc[0];
        bus.i_dump_start = (cyc == 5);
        chk("tog_valid", {31'd0, bus.o_dump_valid}, 32'd1);
        chk("tog_addr", {26'd0, bus.o_dump_addr}, exp_idx);
        chk("tog_data", bus.o_dump_data, exp_mem[exp_idx]);
        if (!injected && exp_idx == 10 && !bus.i_dump_ready) begin
          do_wr = 1'b1;
          bus.i_mem_addr  = 32'h28;
          bus.i_mem_wdata = 32'h5A5A_5A5A;
          bus.i_mem_size  = 2'b10;
          bus.i_mem_write = 1'b1;
        end
        if (bus.i_dump_ready) exp_idx++;
        tick();
        bus.i_mem_write  = 1'b0;
        bus.i_dump_start = 1'b0;
        if (do_wr) begin
          exp_mem[10] = 32'h5A5A_5A5A;
          injected = 1'b1;
        end
        if (exp_idx == N_WORDS) begin
          done_seen = 1'b1;
          break;
        end
      end
      chk("tog_completed", {31'd0, done_seen}, 32'd1);
      chk("tog_injected", {31'd0, injected}, 32'd1);
      chk("tog_done", {31'd0, bus.o_dump_done}, 32'd1);
      tick();
      chk("tog_done_clear", {31'd0, bus.o_dump_done}, 32'd0);
    end

    // Reset in the middle of a dump at index 20.
    load(32'h0, 2'b10, 1'b0);
    chk("pre_rst_load", bus.o_mem_rdata, 32'hCAFE_BABE);
    begin
      logic found;
      found = 1'b0;
      bus.i_dump_ready = 1'b1;
      bus.i_dump_start = 1'b1;
      tick();
      bus.i_dump_start = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
        if (bus.o_dump_valid && bus.o_dump_addr == 6'd20) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      chk("reach_idx20", {31'd0, found}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, bus.o_dump_valid}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.o_dump_done}, 32'd0);
      chk("mid_rst_rdata", bus.o_mem_rdata, 32'h0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("post_rst_no_done", {31'd0, bus.o_dump_done}, 32'd0);
        chk("post_rst_no_valid", {31'd0, bus.o_dump_valid}, 32'd0);
      end
    end
    for (int i = 0; i < N_WORDS; i++) exp_mem[i] = 32'h0;
    dump_full();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
